// File: rtl/dvi_in_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dvi_in_timing_monitor
// Description : Measures the incoming video mode in the pixel domain. It uses
//               deskewed DE and channel-0 HSYNC/VSYNC. It reports active and
//               total width/height once per frame, a published-frame counter,
//               mode stability, mode-change pulses and a loss-of-signal flag.
// Ports       : pclk1x          - pixel clock (sole clock)
//               rst_ps          - synchronous active-high reset
//               de_i            - deskewed data enable
//               hsync_i/vsync_i - active-high syncs
//               h_active_o      - DE run length of last DE line in the frame
//               h_total_o       - cycles between the last two HSYNC rises
//               v_active_o      - DE lines per frame
//               v_total_o       - HSYNC rises per frame
//               frame_cnt_o     - published frame count (wraps)
//               frame_start_o   - one-cycle pulse when measurements update
//               stable_o        - mode held for STABLE_FRAMES identical frames
//               mode_change_o   - one-cycle pulse when stability is lost
//               no_signal_o     - no VSYNC rise for TIMEOUT_CYCLES cycles
// Revision    : 1.0 - initial release
// ============================================================================
module dvi_in_timing_monitor #(
  parameter int CNT_W          = 12,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 4194304
) (
  input  logic             pclk1x,
  input  logic             rst_ps,
  input  logic             de_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic [CNT_W-1:0] h_active_o,
  output logic [CNT_W-1:0] h_total_o,
  output logic [CNT_W-1:0] v_active_o,
  output logic [CNT_W-1:0] v_total_o,
  output logic [15:0]      frame_cnt_o,
  output logic             frame_start_o,
  output logic             stable_o,
  output logic             mode_change_o,
  output logic             no_signal_o
);

  localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int               SC_W     = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  logic hs_prev_q, vs_prev_q, de_prev_q;
  logic hs_rise, vs_rise, de_rise, de_fall;

  assign hs_rise = hsync_i & ~hs_prev_q;
  assign vs_rise = vsync_i & ~vs_prev_q;
  assign de_rise = de_i & ~de_prev_q;
  assign de_fall = ~de_i & de_prev_q;

  // --------------------------------------------------------------------------
  // Line / frame measurement datapath
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] h_cnt_q, line_total_q, de_run_q, line_active_q;
  logic [CNT_W-1:0] hs_lines_q, de_lines_q;
  logic [CNT_W-1:0] fr_ha_q, fr_ht_q, fr_va_q, fr_vt_q;
  logic             pub_q;

  always_ff @(posedge pclk1x) begin
    if (rst_ps) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      h_cnt_q       <= '0;
      line_total_q  <= '0;
      de_run_q      <= '0;
      line_active_q <= '0;
      hs_lines_q    <= '0;
      de_lines_q    <= '0;
      fr_ha_q       <= '0;
      fr_ht_q       <= '0;
      fr_va_q       <= '0;
      fr_vt_q       <= '0;
      pub_q         <= 1'b0;
    end else begin
      hs_prev_q <= hsync_i;
      vs_prev_q <= vsync_i;
      de_prev_q <= de_i;

      // h_cnt counts cycles since the last HSYNC rise, so h_cnt+1 at the next
      // rise is the full line period.
      if (hs_rise) begin
        h_cnt_q      <= '0;
        line_total_q <= sat_inc(h_cnt_q);
      end else begin
        h_cnt_q <= sat_inc(h_cnt_q);
      end

      if (de_rise) begin
        de_run_q <= CNT_W'(1);
      end else if (de_i) begin
        de_run_q <= sat_inc(de_run_q);
      end

      if (de_fall) begin
        line_active_q <= de_run_q;
      end

      // A rise coinciding with VSYNC belongs to the new frame.
      if (vs_rise) begin
        hs_lines_q <= hs_rise ? CNT_W'(1) : '0;
        de_lines_q <= de_rise ? CNT_W'(1) : '0;
      end else begin
        if (hs_rise) hs_lines_q <= sat_inc(hs_lines_q);
        if (de_rise) de_lines_q <= sat_inc(de_lines_q);
      end

      if (vs_rise) begin
        fr_ha_q <= line_active_q;
        fr_ht_q <= line_total_q;
        fr_va_q <= de_lines_q;
        fr_vt_q <= hs_lines_q;
      end

      pub_q <= vs_rise;
    end
  end

  // --------------------------------------------------------------------------
  // Publication, stability and timeout control
  // --------------------------------------------------------------------------
  logic             first_q, first_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             no_signal_q, no_signal_d;
  logic [SC_W-1:0]  stable_cnt_q, stable_cnt_d;
  lock_state_e      state_q, state_d;
  logic             stable_q, stable_d;
  logic             mode_change_q, mode_change_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] h_active_q, h_active_d;
  logic [CNT_W-1:0] h_total_q, h_total_d;
  logic [CNT_W-1:0] v_active_q, v_active_d;
  logic [CNT_W-1:0] v_total_q, v_total_d;
  logic             frame_eq;

  // The published outputs double as the "previous frame" for comparison.
  assign frame_eq = (fr_ha_q == h_active_q) && (fr_ht_q == h_total_q) &&
                    (fr_va_q == v_active_q) && (fr_vt_q == v_total_q);

  always_comb begin
    first_d       = first_q;
    to_cnt_d      = to_cnt_q;
    no_signal_d   = no_signal_q;
    stable_cnt_d  = stable_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = 1'b0;
    h_active_d    = h_active_q;
    h_total_d     = h_total_q;
    v_active_d    = v_active_q;
    v_total_d     = v_total_q;
    state_d       = state_q;
    stable_d      = stable_q;
    mode_change_d = 1'b0;

    if (pub_q) begin
      if (first_q) begin
        // Partial frame since reset or signal loss: drop it.
        first_d = 1'b0;
      end else begin
        h_active_d    = fr_ha_q;
        h_total_d     = fr_ht_q;
        v_active_d    = fr_va_q;
        v_total_d     = fr_vt_q;
        frame_start_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 16'd1;
        if (frame_eq) begin
          stable_cnt_d = (stable_cnt_q == SC_MAX) ? stable_cnt_q
                                                  : stable_cnt_q + SC_W'(1);
        end else begin
          stable_cnt_d = '0;
        end
      end
    end

    // VSYNC rise has priority over a timeout in the same cycle.
    if (vs_rise) begin
      to_cnt_d    = '0;
      no_signal_d = 1'b0;
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_q == TO_LAST) begin
        no_signal_d  = 1'b1;
        stable_cnt_d = '0;
        first_d      = 1'b1;
        h_active_d   = '0;
        h_total_d    = '0;
        v_active_d   = '0;
        v_total_d    = '0;
      end
    end

    if (stable_cnt_d == '0) begin
      state_d = ST_UNLOCKED;
    end else if (stable_cnt_d == SC_MAX) begin
      state_d = ST_LOCKED;
    end else begin
      state_d = ST_LOCKING;
    end

    stable_d      = (state_d == ST_LOCKED);
    mode_change_d = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
  end

  always_ff @(posedge pclk1x) begin
    if (rst_ps) begin
      first_q       <= 1'b1;
      to_cnt_q      <= '0;
      no_signal_q   <= 1'b1;
      stable_cnt_q  <= '0;
      state_q       <= ST_UNLOCKED;
      stable_q      <= 1'b0;
      mode_change_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      h_active_q    <= '0;
      h_total_q     <= '0;
      v_active_q    <= '0;
      v_total_q     <= '0;
    end else begin
      first_q       <= first_d;
      to_cnt_q      <= to_cnt_d;
      no_signal_q   <= no_signal_d;
      stable_cnt_q  <= stable_cnt_d;
      state_q       <= state_d;
      stable_q      <= stable_d;
      mode_change_q <= mode_change_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      h_active_q    <= h_active_d;
      h_total_q     <= h_total_d;
      v_active_q    <= v_active_d;
      v_total_q     <= v_total_d;
    end
  end

  assign h_active_o    = h_active_q;
  assign h_total_o     = h_total_q;
  assign v_active_o    = v_active_q;
  assign v_total_o     = v_total_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign frame_start_o = frame_start_q;
  assign stable_o      = stable_q;
  assign mode_change_o = mode_change_q;
  assign no_signal_o   = no_signal_q;

endmodule
`default_nettype wire
